param_rf_mp: RTL and testbench

Parametrised multi-port register file: NWR write ports and NRD read ports over a DEPTH x DATA_W array.
- Per-entry valid bits and a bulk-clear request.
- Optional same-cycle write-to-read bypass.
- Selectable combinational or registered read.
Successor to the single-port register files used in the yosys front-end tests; the generalised storage primitive for LGraph memory-inference regressions.

---
 rtl/param_rf_mp_if.sv | 26 ++
 rtl/param_rf_mp.sv | 103 ++++++++++
 tb/tb_param_rf_mp.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/param_rf_mp_if.sv
// Bus bundle for param_rf_mp: write ports, read addresses, bulk clear and read results.
// The master drives the requests and the slave (the register file) drives q and q_valid.
interface param_rf_mp_if #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 3,
    parameter int NWR    = 2,
    parameter int NRD    = 2
);
    logic                     clr;
    logic [NWR-1:0]           we;
    logic [NWR*ADDR_W-1:0]    waddr;
    logic [NWR*DATA_W-1:0]    din;
    logic [NRD*ADDR_W-1:0]    raddr;
    logic [NRD*DATA_W-1:0]    q;
    logic [NRD-1:0]           q_valid;

    modport master (
        output clr, we, waddr, din, raddr,
        input  q, q_valid
    );

    modport slave (
        input  clr, we, waddr, din, raddr,
        output q, q_valid
    );
endinterface

// File: rtl/param_rf_mp.sv
// Multi-port register file with per-entry valid bits, bulk clear, optional write-to-read
// bypass, and a combinational or registered read path.
module param_rf_mp #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8,
    parameter int NWR    = 2,
    parameter int NRD    = 2,
    parameter int RD_LAT = 0,
    parameter int BYPASS = 1
) (
    input logic          clk,
    input logic          rst,
    param_rf_mp_if.slave bus
);

    if (DEPTH > (1 << ADDR_W) || NWR < 1 || NRD < 1 || (RD_LAT != 0 && RD_LAT != 1)) begin : g_bad_params
        $error("param_rf_mp: illegal parameter combination");
    end

    logic [DATA_W-1:0]     mem       [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [DATA_W-1:0]     nxt_mem   [DEPTH];
    logic [DEPTH-1:0]      nxt_valid;
    logic [DATA_W-1:0]     view_mem  [DEPTH];
    logic [DEPTH-1:0]      view_valid;
    logic [NRD*DATA_W-1:0] rd_q;
    logic [NRD-1:0]        rd_valid;

    // Post-edge state of every entry. Ports are scanned in ascending order so the
    // highest-index port wins a conflict; out-of-range addresses never match an entry.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            nxt_mem[e]   = mem[e];
            nxt_valid[e] = valid[e] & ~bus.clr;
            for (int i = 0; i < NWR; i++) begin
                if (!rst && bus.we[i] && bus.waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(e)) begin
                    nxt_mem[e]   = bus.din[i*DATA_W +: DATA_W];
                    nxt_valid[e] = 1'b1;
                end
            end
        end
    end

    // NOTE: the array is cleared by reset on purpose, so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
            valid <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= nxt_mem[e];
            end
            valid <= nxt_valid;
        end
    end

    // Write-first reads see the post-edge state, read-first reads see the current array.
    if (BYPASS != 0) begin : g_bypass
        assign view_mem   = nxt_mem;
        assign view_valid = nxt_valid;
    end else begin : g_no_bypass
        assign view_mem   = mem;
        assign view_valid = valid;
    end

    always_comb begin
        rd_q     = '0;
        rd_valid = '0;
        for (int j = 0; j < NRD; j++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (bus.raddr[j*ADDR_W +: ADDR_W] == ADDR_W'(e)) begin
                    rd_q[j*DATA_W +: DATA_W] = view_mem[e];
                    rd_valid[j]              = view_valid[e];
                end
            end
        end
    end

    if (RD_LAT == 1) begin : g_rd_reg
        logic [NRD*DATA_W-1:0] q_r;
        logic [NRD-1:0]        q_valid_r;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q_r       <= '0;
                q_valid_r <= '0;
            end else begin
                q_r       <= rd_q;
                q_valid_r <= rd_valid;
            end
        end

        assign bus.q       = q_r;
        assign bus.q_valid = q_valid_r;
    end else begin : g_rd_comb
        assign bus.q       = rd_q;
        assign bus.q_valid = rd_valid;
    end

endmodule

// File: tb/tb_param_rf_mp.sv
// Directed bench for param_rf_mp: four configurations share one stimulus stream and are
// checked against hand-computed values.
module tb_param_rf_mp;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [1:0] we;
    logic [5:0] waddr;
    logic [3:0] din;
    logic [5:0] raddr;

    int n_tests;
    int n_fail;

    param_rf_mp_if #(.DATA_W(2), .ADDR_W(3), .NWR(2), .NRD(2)) if_a ();
    param_rf_mp_if #(.DATA_W(2), .ADDR_W(3), .NWR(2), .NRD(2)) if_b ();
    param_rf_mp_if #(.DATA_W(2), .ADDR_W(3), .NWR(2), .NRD(2)) if_c ();
    param_rf_mp_if #(.DATA_W(2), .ADDR_W(3), .NWR(2), .NRD(2)) if_d ();

    assign if_a.clr = clr;  assign if_a.we = we;  assign if_a.waddr = waddr;
    assign if_a.din = din;  assign if_a.raddr = raddr;
    assign if_b.clr = clr;  assign if_b.we = we;  assign if_b.waddr = waddr;
    assign if_b.din = din;  assign if_b.raddr = raddr;
    assign if_c.clr = clr;  assign if_c.we = we;  assign if_c.waddr = waddr;
    assign if_c.din = din;  assign if_c.raddr = raddr;
    assign if_d.clr = clr;  assign if_d.we = we;  assign if_d.waddr = waddr;
    assign if_d.din = din;  assign if_d.raddr = raddr;

    // a: defaults (comb read, write-first); b: read-first; c: registered read; d: DEPTH=6
    param_rf_mp #(.RD_LAT(0), .BYPASS(1)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    param_rf_mp #(.RD_LAT(0), .BYPASS(0)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    param_rf_mp #(.RD_LAT(1), .BYPASS(1)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    param_rf_mp #(.DEPTH(6))              u_d (.clk(clk), .rst(rst), .bus(if_d.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we  = 2'b00;
        clr = 1'b0;
    endtask

    task automatic wr(input int p, input logic [2:0] a, input logic [1:0] d);
        we[p]           = 1'b1;
        waddr[p*3 +: 3] = a;
        din[p*2 +: 2]   = d;
    endtask

    function automatic logic [1:0] fill_val(input int e);
        return 2'((e + 1) & 3);
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst   = 1'b1;
        clr   = 1'b0;
        we    = '0;
        waddr = '0;
        din   = '0;
        raddr = {3'd1, 3'd0};

        // Reset state, both comb and registered read paths
        #2;
        check("rst_a_q", 32'(if_a.q), 32'h0);
        check("rst_a_qv", 32'(if_a.q_valid), 32'h0);
        check("rst_c_q", 32'(if_c.q), 32'h0);
        check("rst_c_qv", 32'(if_c.q_valid), 32'h0);
        #10;
        rst = 1'b0;

        // Simple write then read
        wr(0, 3'd3, 2'b10);
        step();
        idle();
        raddr[2:0] = 3'd3;
        #1;
        check("wr_a_q0", 32'(if_a.q[1:0]), 32'h2);
        check("wr_a_qv0", 32'(if_a.q_valid[0]), 32'h1);
        check("wr_b_q0", 32'(if_b.q[1:0]), 32'h2);

        // Conflict: port1 wins
        wr(0, 3'd5, 2'b01);
        wr(1, 3'd5, 2'b11);
        step();
        idle();
        raddr[2:0] = 3'd5;
        #1;
        check("conf_a_q0", 32'(if_a.q[1:0]), 32'h3);
        check("conf_a_qv0", 32'(if_a.q_valid[0]), 32'h1);
        check("conf_d_q0", 32'(if_d.q[1:0]), 32'h3);

        // Same-cycle bypass vs read-first
        raddr[2:0] = 3'd2;
        wr(0, 3'd2, 2'b11);
        #1;
        check("byp_a_q0", 32'(if_a.q[1:0]), 32'h3);
        check("byp_a_qv0", 32'(if_a.q_valid[0]), 32'h1);
        check("nobyp_b_q0", 32'(if_b.q[1:0]), 32'h0);
        check("nobyp_b_qv0", 32'(if_b.q_valid[0]), 32'h0);
        step();
        idle();
        #1;
        check("nobyp_b_q0_after", 32'(if_b.q[1:0]), 32'h3);
        check("nobyp_b_qv0_after", 32'(if_b.q_valid[0]), 32'h1);

        // Registered read: one cycle from address to data
        wr(1, 3'd4, 2'b01);
        step();
        idle();
        raddr[5:3] = 3'd4;
        #1;
        check("lat_a_q1", 32'(if_a.q[3:2]), 32'h1);
        check("lat_c_qv1_early", 32'(if_c.q_valid[1]), 32'h0);
        check("lat_c_q1_early", 32'(if_c.q[3:2]), 32'h0);
        step();
        check("lat_c_q1", 32'(if_c.q[3:2]), 32'h1);
        check("lat_c_qv1", 32'(if_c.q_valid[1]), 32'h1);

        // Fill all entries, then clr together with a write to addr6
        for (int k = 0; k < 4; k++) begin
            wr(0, 3'(2 * k), fill_val(2 * k));
            wr(1, 3'(2 * k + 1), fill_val(2 * k + 1));
            step();
        end
        idle();
        raddr = {3'd1, 3'd6};
        clr = 1'b1;
        wr(0, 3'd6, 2'b10);
        #1;
        check("clrbyp_a_q0", 32'(if_a.q[1:0]), 32'h2);
        check("clrbyp_a_qv0", 32'(if_a.q_valid[0]), 32'h1);
        check("clrbyp_a_q1", 32'(if_a.q[3:2]), 32'(fill_val(1)));
        check("clrbyp_a_qv1", 32'(if_a.q_valid[1]), 32'h0);
        check("clrbyp_b_qv1", 32'(if_b.q_valid[1]), 32'h1);
        step();
        idle();
        #1;
        check("clr_c_q0", 32'(if_c.q[1:0]), 32'h2);
        check("clr_c_qv0", 32'(if_c.q_valid[0]), 32'h1);
        check("clr_c_qv1", 32'(if_c.q_valid[1]), 32'h0);
        check("clr_a_q1", 32'(if_a.q[3:2]), 32'(fill_val(1)));
        for (int e = 0; e < 8; e++) begin
            raddr[2:0] = 3'(e);
            #1;
            check($sformatf("clr_a_qv_%0d", e), 32'(if_a.q_valid[0]), (e == 6) ? 32'h1 : 32'h0);
        end

        // Asynchronous reset between edges while a write is pending
        step();
        raddr[2:0] = 3'd6;
        wr(0, 3'd6, 2'b01);
        #1;
        check("prerst_a_q0", 32'(if_a.q[1:0]), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_a_q0", 32'(if_a.q[1:0]), 32'h0);
        check("arst_a_qv0", 32'(if_a.q_valid[0]), 32'h0);
        check("arst_c_q0", 32'(if_c.q[1:0]), 32'h0);
        step();
        idle();
        rst = 1'b0;
        #1;
        check("postrst_a_q0", 32'(if_a.q[1:0]), 32'h0);
        check("postrst_a_qv0", 32'(if_a.q_valid[0]), 32'h0);
        raddr[2:0] = 3'd5;
        #1;
        check("postrst_a_qv5", 32'(if_a.q_valid[0]), 32'h0);

        // DEPTH=6: out-of-range write ignored, out-of-range read returns 0
        wr(0, 3'd7, 2'b11);
        step();
        idle();
        raddr = {3'd1, 3'd7};
        #1;
        check("oor_a_q0", 32'(if_a.q[1:0]), 32'h3);
        check("oor_a_qv0", 32'(if_a.q_valid[0]), 32'h1);
        check("oor_d_q0", 32'(if_d.q[1:0]), 32'h0);
        check("oor_d_qv0", 32'(if_d.q_valid[0]), 32'h0);
        check("oor_d_qv1", 32'(if_d.q_valid[1]), 32'h0);
        check("oor_d_q1", 32'(if_d.q[3:2]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
